// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and painter colour constants.
package vga_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [11:0] rgb_t;

  // 640x480@60 Hz defaults
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_SYNC_POL    = 1'b0;
  localparam int   DEF_SCROLL_DIV  = 2;
  localparam int   DEF_SCROLL_STEP = 1;

  // Colours used by the downstream message painter (4:4:4 RGB)
  localparam rgb_t COLOR_BLACK = 12'h000;
  localparam rgb_t COLOR_WHITE = 12'hFFF;
  localparam rgb_t COLOR_TEXT  = 12'h0F0;
  localparam rgb_t COLOR_BG    = 12'h004;

  // Inclusive range test used by the sync decoders
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/scroll_ctrl.sv
// Frame divider plus modular horizontal scroll offset; advances only on the frame-wrap strobe.
module scroll_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int SCROLL_DIV  = DEF_SCROLL_DIV,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_wrap,
  input  logic       i_scroll_en,
  input  logic       i_scroll_dir,
  output logic [9:0] o_scroll_x
);

  localparam int                 DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [10:0]        STEP_W   = 11'(SCROLL_STEP);
  localparam logic [10:0]        HA_W     = 11'(H_ACTIVE);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_scroll;
  logic [10:0]      w_inc_raw;
  logic [10:0]      w_dec_raw;
  logic [10:0]      w_inc;
  logic [10:0]      w_dec;
  logic [9:0]       w_next_scroll;
  logic             w_div_wrap;

  // Candidate next offsets for both directions, folded back into 0..H_ACTIVE-1
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_inc_raw = {1'b0, r_scroll} + STEP_W;
    w_dec_raw = {1'b0, r_scroll} - STEP_W;
    w_inc     = w_inc_raw;
    w_dec     = w_dec_raw;
    if (w_inc_raw >= HA_W) w_inc = w_inc_raw - HA_W;
    // Bit 10 set means the 11-bit subtraction went negative
    if (w_dec_raw[10])     w_dec = w_dec_raw + HA_W;
    w_next_scroll = i_scroll_dir ? w_dec[9:0] : w_inc[9:0];
    w_div_wrap    = (r_div == DIV_LAST);
  end

  // Divider and offset only move on the frame-wrap edge, so the offset is stable for a whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_scroll <= '0;
    end else if (i_frame_wrap && i_scroll_en) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap) r_scroll <= w_next_scroll;
    end
  end

  assign o_scroll_x = r_scroll;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/data-enable decode and line/frame strobes, all registered
// from the next counter value so every output lines up with the sx/sy it describes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = DEF_SYNC_POL,
  parameter int   SCROLL_DIV  = DEF_SCROLL_DIV,
  parameter int   SCROLL_STEP = DEF_SCROLL_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scroll_en,
  input  logic       scroll_dir,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       data_en,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] scroll_x
);

  localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t r_sx;
  coord_t r_sy;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_data_en;
  logic   r_line_start;
  logic   r_frame_start;

  coord_t w_sx_next;
  coord_t w_sy_next;
  logic   w_sx_last;
  logic   w_sy_last;
  logic   w_frame_wrap;

  // Next raster position; the frame wraps when (H_TOTAL-1, V_TOTAL-1) rolls over to (0,0)
  always_comb begin
    w_sx_last    = (r_sx == H_LAST);
    w_sy_last    = (r_sy == V_LAST);
    w_frame_wrap = w_sx_last && w_sy_last;
    w_sx_next    = w_sx_last ? '0 : r_sx + 1'b1;
    w_sy_next    = r_sy;
    if (w_sx_last) w_sy_next = w_sy_last ? '0 : r_sy + 1'b1;
  end

  // Counters and every decoded output register together from the next position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx          <= '0;
      r_sy          <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_data_en     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_sx          <= w_sx_next;
      r_sy          <= w_sy_next;
      r_hsync       <= in_window(w_sx_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= in_window(w_sy_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      r_data_en     <= (w_sx_next < H_ACT) && (w_sy_next < V_ACT);
      r_line_start  <= (w_sx_next == '0);
      r_frame_start <= (w_sx_next == '0) && (w_sy_next == '0);
    end
  end

  scroll_ctrl #(
    .H_ACTIVE   (H_ACTIVE),
    .SCROLL_DIV (SCROLL_DIV),
    .SCROLL_STEP(SCROLL_STEP)
  ) u_scroll_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_wrap(w_frame_wrap),
    .i_scroll_en (scroll_en),
    .i_scroll_dir(scroll_dir),
    .o_scroll_x  (scroll_x)
  );

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign data_en     = r_data_en;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the pixel clock: screen coordinates, syncs, data-enable, line/frame strobes, and a frame-synchronous horizontal scroll offset for the running line. It sits directly upstream of the message painter. That stage consumes `sx`, `sy` and `data_en`, and indexes its bitmap with `(sx + scroll_x) mod H_ACTIVE`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: asserted sync level (0 = negative)
- `SCROLL_DIV`, 2: frames per scroll step (≥1)
- `SCROLL_STEP`, 1: pixels per scroll step (1..H_ACTIVE-1)

Ports:
- `clk` in 1: pixel clock (25.175 MHz nominal)
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `scroll_en` in 1: enable scroll advance
- `scroll_dir` in 1: 0 = text moves left (offset increments), 1 = right (decrements)
- `sx` out 10: horizontal counter, 0..H_TOTAL-1 (800)
- `sy` out 10: vertical counter, 0..V_TOTAL-1 (525)
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `data_en` out 1: high in the active area
- `line_start` out 1: one-cycle pulse when sx==0
- `frame_start` out 1: one-cycle pulse when sx==0 and sy==0
- `scroll_x` out 10: scroll offset, 0..H_ACTIVE-1

## Operation
- `sx` increments every clock. At H_TOTAL-1 it wraps to 0 and `sy` increments. `sy` wraps to 0 after V_TOTAL-1.
- All outputs are registered. Each output is computed from the next counter value, so `hsync`, `vsync`, `data_en` and the strobes are aligned to the `sx`/`sy` they describe, with zero skew.
- `data_en` = (sx < H_ACTIVE) && (sy < V_ACTIVE).
- `hsync` = SYNC_POL when sx ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); otherwise !SYNC_POL.
- `vsync` = SYNC_POL when sy ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491); otherwise !SYNC_POL.
- Scroll controller, advanced only on the frame-wrap edge, i.e. the edge where (sx,sy) goes (799,524) → (0,0):
  - If `scroll_en`=0, the frame divider and `scroll_x` hold.
  - If `scroll_en`=1, the divider counts 0..SCROLL_DIV-1. When it wraps, `scroll_x` advances by SCROLL_STEP.
  - Left (dir=0): the offset increments. If the result ≥ H_ACTIVE, subtract H_ACTIVE.
  - Right (dir=1): the offset decrements. If the result < 0, add H_ACTIVE.
  - Arithmetic uses 11 bits internally and the result is truncated to 10 bits.
- `scroll_en` and `scroll_dir` are sampled only on the frame-wrap edge. `scroll_x` is therefore constant for an entire frame and never tears mid-frame.

## Timing
- Reset (asynchronous assert) values:
  - `sx`=0, `sy`=0, `scroll_x`=0, divider=0
  - `hsync`=`vsync`=!SYNC_POL
  - `data_en`=0, `line_start`=0, `frame_start`=0
- First edge after `rst_n` deasserts: `sx`=1, `sy`=0, `data_en`=1. Pixel (0,0) of the first frame is blanked by design.
- Line period is 800 clocks; frame period is 420 000 clocks.
- `line_start` is high for exactly 1 clock per line. `frame_start` is high for 1 clock per frame, coincident with a `line_start` pulse.
- `scroll_x` changes on the same edge that `frame_start` rises, so it is valid before the first active pixel.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The timing restarts from (0,0).

## Structure
- Package `vga_pkg`:
  - default timing localparams and derived H_TOTAL/V_TOTAL
  - the `coord_t` typedef (logic [9:0])
  - color constants shared with the painter
- Sub-module `scroll_ctrl`: frame divider plus modular offset update. Inputs are `clk`, `rst_n`, a frame-wrap strobe, `scroll_en` and `scroll_dir`; output is `scroll_x`.
- Counter and sync decode stay in the top level.

## Test plan
- Reset release, run 2 frames:
  - `sx` wraps 799→0
  - `sy` wraps 524→0
  - `frame_start` pulses exactly 420 000 clocks apart
- One line: `hsync` low for exactly 96 clocks, starting at sx=656. `data_en` high sx=0..639 when sy<480 and low at sy=480.
- One frame: `vsync` low for exactly 1600 clocks (sy=490..491). `line_start` count = 525.
- `scroll_en`=1, dir=0, SCROLL_DIV=2, STEP=1: `scroll_x` = 0,0,1,1,2 across frames 0..4. It changes only on `frame_start` edges.
- Wrap: preload via STEP=300, dir=0: 0→300→600→260. Then dir=1 from 0 with STEP=1 gives 639.
- Assert `rst_n` low at sx=400, sy=200 with scroll_x=5: outputs return to their reset values that cycle, and `scroll_x`=0 after release.
